// File: rtl/audio_sample_player.sv
// Paces combinational sample-ROM reads at the audio rate, attenuates each word and
// hands it downstream with a one-cycle valid strobe. Supports one-shot, looped and stopped playback.
module audio_sample_player #(
    parameter int ADDR_W  = 14,
    parameter int DATA_W  = 16,
    parameter int CLK_DIV = 1042,
    parameter int DIV_W   = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              loop_en,
    input  logic [ADDR_W-1:0] end_addr,
    input  logic [2:0]        volume,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] sample_out,
    output logic              sample_valid,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PLAY,
        S_DONE
    } state_t;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    state_t              r_state;
    logic [DIV_W-1:0]    r_div;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_sample;
    logic                r_valid;
    logic                r_busy;
    logic                r_done;

    logic                     w_tick;
    logic                     w_last;
    logic signed [DATA_W-1:0] w_rom_s;
    logic signed [DATA_W-1:0] w_atten;

    assign w_tick  = (r_state == S_PLAY) && (r_div == DIV_LAST);
    assign w_last  = (r_addr == end_addr);
    assign w_rom_s = rom_data;
    // Arithmetic shift keeps the sign so negative samples stay negative when attenuated.
    assign w_atten = w_rom_s >>> volume;

    // NOTE: every state register here uses non-blocking assignment so all updates
    // see the values from before the edge; blocking here would create ordering races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_div    <= '0;
            r_addr   <= '0;
            r_sample <= '0;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_div  <= '0;
                    r_addr <= '0;
                    if (start && !stop) begin
                        r_state <= S_PLAY;
                        r_busy  <= 1'b1;
                    end
                end
                S_PLAY: begin
                    if (stop) begin
                        // Stop wins over a coincident tick: no strobe, no done.
                        r_state  <= S_IDLE;
                        r_busy   <= 1'b0;
                        r_div    <= '0;
                        r_addr   <= '0;
                        r_sample <= '0;
                    end else if (w_tick) begin
                        r_div    <= '0;
                        r_sample <= w_atten;
                        r_valid  <= 1'b1;
                        if (w_last) begin
                            r_addr <= '0;
                            if (!loop_en) begin
                                r_state <= S_DONE;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end
                        end else begin
                            r_addr <= r_addr + ADDR_W'(1);
                        end
                    end else begin
                        r_div <= r_div + DIV_W'(1);
                    end
                end
                S_DONE: begin
                    r_sample <= '0;
                    r_state  <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign rom_addr     = r_addr;
    assign sample_out   = r_sample;
    assign sample_valid = r_valid;
    assign busy         = r_busy;
    assign done         = r_done;

endmodule

// File: tb/tb_audio_sample_player.sv
// Randomized self-checking bench for audio_sample_player; expected outputs come from
// a cycle-count model of playback (sample n appears at 4*(n+1) cycles after PLAY entry).
module tb_audio_sample_player;

    localparam int ADDR_W  = 4;
    localparam int DATA_W  = 16;
    localparam int CLK_DIV = 4;
    localparam int DIV_W   = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              stop = 1'b0;
    logic              loop_en = 1'b0;
    logic [ADDR_W-1:0] end_addr = '0;
    logic [2:0]        volume = '0;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic [DATA_W-1:0] sample_out;
    logic              sample_valid;
    logic              busy;
    logic              done;

    logic [DATA_W-1:0] rom_mem [2**ADDR_W];
    int total = 0;
    int bad   = 0;

    assign rom_data = rom_mem[rom_addr];

    always #5 clk = ~clk;

    audio_sample_player #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .CLK_DIV(CLK_DIV),
        .DIV_W  (DIV_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .stop        (stop),
        .loop_en     (loop_en),
        .end_addr    (end_addr),
        .volume      (volume),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .sample_out  (sample_out),
        .sample_valid(sample_valid),
        .busy        (busy),
        .done        (done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Attenuation as signed division rounded toward minus infinity.
    function automatic logic [DATA_W-1:0] atten(input logic [DATA_W-1:0] w, input int vol);
        int s;
        int d;
        int q;
        s = int'($signed(w));
        d = 1 << vol;
        q = s / d;
        if ((s % d) != 0 && s < 0) q = q - 1;
        return q[DATA_W-1:0];
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_busy"},   32'(busy), 0);
        check({tag, "_valid"},  32'(sample_valid), 0);
        check({tag, "_done"},   32'(done), 0);
        check({tag, "_sample"}, 32'(sample_out), 0);
        check({tag, "_addr"},   32'(rom_addr), 0);
    endtask

    // k counts clock edges since PLAY entry; stop_k>0 asserts stop for edge stop_k.
    task automatic run_trial(input int e, input int lp, input int vol, input int stop_k);
        int n;
        int ns;
        int last_k;
        end_addr = ADDR_W'(e);
        loop_en  = lp[0];
        volume   = 3'(vol);
        ns       = e + 1;
        last_k   = 4 * ns;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 400; k++) begin
            if (k > 0) begin
                @(posedge clk);
                @(negedge clk);
            end
            stop = 1'b0;
            if (stop_k > 0 && k == stop_k) begin
                check_idle("stopped");
                break;
            end
            if (lp == 0 && k == last_k + 1) begin
                check_idle("after_done");
                break;
            end
            if (k == 399) check("trial_timeout", 1, 0);
            n = k / CLK_DIV;
            check("busy",  32'(busy), (lp != 0 || n < ns) ? 1 : 0);
            check("done",  32'(done), (lp == 0 && k == last_k) ? 1 : 0);
            check("valid", 32'(sample_valid), (k > 0 && k % CLK_DIV == 0) ? 1 : 0);
            check("addr",  32'(rom_addr), n % ns);
            check("sample", 32'(sample_out),
                  (n == 0) ? 0 : 32'(atten(rom_mem[(n - 1) % ns], vol)));
            stop = (stop_k > 0 && k + 1 == stop_k);
            if (lp == 0 && k + 1 == last_k + 1) start = 1'b1;
            else if (lp == 0 && k + 1 > last_k + 1) start = 1'b0;
            else start = 1'($urandom_range(0, 1));
        end
        start = 1'b0;
        stop  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("idle_hold_busy", 32'(busy), 0);
        check("idle_hold_valid", 32'(sample_valid), 0);
    endtask

    initial begin
        int e;
        int lp;
        int sk;
        for (int i = 0; i < 2**ADDR_W; i++) rom_mem[i] = DATA_W'(i);
        #2;
        check_idle("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // One-shot 0..3, then a loop over 0..2 stopped after seven samples.
        run_trial(3, 0, 0, 0);
        run_trial(2, 1, 0, 4 * 7 + 2);

        // Attenuation boundaries with a single-word one-shot.
        rom_mem[0] = 16'h8000;
        run_trial(0, 0, 2, 0);
        rom_mem[0] = 16'h7FFF;
        run_trial(0, 0, 2, 0);
        rom_mem[0] = 16'h8000;
        run_trial(0, 0, 0, 0);

        // Stop exactly on a tick edge.
        for (int i = 0; i < 2**ADDR_W; i++) rom_mem[i] = DATA_W'(i + 1);
        run_trial(3, 1, 0, 8);

        // start and stop together in IDLE.
        @(negedge clk);
        start = 1'b1;
        stop  = 1'b1;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            check("start_stop_busy", 32'(busy), 0);
        end
        start = 1'b0;
        stop  = 1'b0;

        for (int t = 0; t < 12; t++) begin
            for (int i = 0; i < 2**ADDR_W; i++) rom_mem[i] = DATA_W'($urandom);
            e  = $urandom_range(0, 6);
            lp = $urandom_range(0, 1);
            if (lp != 0) sk = 4 * $urandom_range(1, 8) + $urandom_range(0, 3);
            else sk = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4 * (e + 1)) : 0;
            run_trial(e, lp, $urandom_range(0, 7), sk);
        end

        // Asynchronous reset between clock edges mid-playback.
        for (int i = 0; i < 2**ADDR_W; i++) rom_mem[i] = DATA_W'(i + 100);
        end_addr = 5;
        loop_en  = 1'b1;
        volume   = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("pre_reset_sample", 32'(sample_out), 101);
        check("pre_reset_addr", 32'(rom_addr), 2);
        #1;
        rst_n = 1'b0;
        #1;
        check_idle("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) begin
            @(posedge clk);
            @(negedge clk);
            check("post_reset_busy", 32'(busy), 0);
            check("post_reset_valid", 32'(sample_valid), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
